// File: rtl/axis_uart_rx_if.sv
// AXI4-Stream style valid/ready byte channel.
// Master drives tvalid/tdata, slave drives tready.
interface axis_if #(
    parameter int W = 8
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/axis_uart_rx.sv
// 16x oversampled UART receiver feeding a FWFT FIFO
// that is drained over an AXI-Stream master port.
module axis_uart_rx #(
    parameter int CLOCK      = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  uart_rx,
    axis_if.master m_axis,
    output logic  frame_err,
    output logic  overrun
);

    localparam int DIV = CLOCK / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;

    generate
        if (DIV < 1) begin : g_bad_div
            $error("CLOCK too low for BAUD_RATE*16");
        end
        if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2, >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          sync1;
    logic          rx_s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    tcnt;
    logic          smp7;
    logic          smp8;
    logic          maj;
    logic          dec;
    logic          last;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    logic          push;
    logic          ferr_set;
    logic          shift_en;
    logic          bit_inc;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          push_ok;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
        end
    end

    // Divider and tick counter are held at zero in IDLE so
    // sampling phase is fixed by the detected start edge.
    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            div_cnt <= '0;
            tcnt    <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            tcnt    <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            tcnt    <= tcnt + 4'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            smp7 <= 1'b1;
            smp8 <= 1'b1;
        end else if (tick) begin
            if (tcnt == 4'd7) smp7 <= rx_s;
            if (tcnt == 4'd8) smp8 <= rx_s;
        end
    end

    assign maj  = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
    assign dec  = tick && (tcnt == 4'd9);
    assign last = tick && (tcnt == 4'd15);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (dec && maj) state_nxt = IDLE;
                else if (last)  state_nxt = DATA;
            end
            DATA: begin
                if (last && bit_cnt == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (dec) state_nxt = maj ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        ferr_set = 1'b0;
        shift_en = 1'b0;
        bit_inc  = 1'b0;
        unique case (state)
            DATA: begin
                shift_en = dec;
                bit_inc  = last;
            end
            STOP: begin
                push     = dec && maj;
                ferr_set = dec && !maj;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state != DATA) bit_cnt <= '0;
            else if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {maj, shreg[7:1]};
        end
    end

    // A full FIFO still takes the byte if the head leaves
    // in the same cycle.
    assign pop     = m_axis.tvalid && m_axis.tready;
    assign push_ok = push && ((count < CW'(FIFO_DEPTH)) || pop);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      count <= count + CW'(1);
            else if (pop && !push_ok) count <= count - CW'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mem <= '{default: '0};
        end else if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= push && !push_ok;
        end
    end

    assign m_axis.tvalid = (count != '0);
    assign m_axis.tdata  = mem[rd_ptr];

endmodule
